// File: rtl/tbp_cmd_issuer_if.sv
// Command, processor-serial and response signal bundle for tbp_cmd_issuer.
// The master side is the issuer; the slave side is the command source, processor and response sink.
interface tbp_cmd_issuer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;

    logic [7:0]  proc_data_in;
    logic [2:0]  proc_opcode;
    logic        proc_data_valid;
    logic [15:0] proc_data_out;
    logic        proc_data_ready;
    logic [3:0]  proc_status;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [2:0]  rsp_op;
    logic        rsp_timeout;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  proc_data_out, proc_data_ready, proc_status,
        input  rsp_ready,
        output cmd_ready,
        output proc_data_in, proc_opcode, proc_data_valid,
        output rsp_valid, rsp_result, rsp_flags, rsp_op, rsp_timeout
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output proc_data_out, proc_data_ready, proc_status,
        output rsp_ready,
        input  cmd_ready,
        input  proc_data_in, proc_opcode, proc_data_valid,
        input  rsp_valid, rsp_result, rsp_flags, rsp_op, rsp_timeout
    );
endinterface

// File: rtl/tbp_cmd_issuer.sv
// Sequences one command at a time onto the processor serial interface (beat A, gap, optional beat B).
// It then waits for a rising data_ready or a timeout and returns the result on the response port.
module tbp_cmd_issuer #(
    parameter int unsigned OPERAND_GAP      = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 256,
    parameter logic [7:0]  TWO_OPERAND_MASK = 8'hBE
) (
    input  logic             clk,
    input  logic             rst,
    tbp_cmd_issuer_if.master bus
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > OPERAND_GAP) ? TIMEOUT_CYCLES : OPERAND_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BEAT_A = 3'd1,
        S_GAP    = 3'd2,
        S_BEAT_B = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t             r_state,       w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,         w_cnt_nxt;
    logic [2:0]         r_op,          w_op_nxt;
    logic [7:0]         r_b,           w_b_nxt;
    logic               r_ready_d;
    logic [7:0]         r_data_in,     w_data_in_nxt;
    logic [2:0]         r_opcode,      w_opcode_nxt;
    logic               r_data_valid,  w_data_valid_nxt;
    logic               r_rsp_valid,   w_rsp_valid_nxt;
    logic [15:0]        r_rsp_result,  w_rsp_result_nxt;
    logic [3:0]         r_rsp_flags,   w_rsp_flags_nxt;
    logic [2:0]         r_rsp_op,      w_rsp_op_nxt;
    logic               r_rsp_timeout, w_rsp_timeout_nxt;
    logic               w_edge;

    // Only a fresh low-to-high transition counts as a new result.
    assign w_edge = bus.proc_data_ready & ~r_ready_d;

    assign bus.cmd_ready       = (r_state == S_IDLE) & ~rst;
    assign bus.proc_data_in    = r_data_in;
    assign bus.proc_opcode     = r_opcode;
    assign bus.proc_data_valid = r_data_valid;
    assign bus.rsp_valid       = r_rsp_valid;
    assign bus.rsp_result      = r_rsp_result;
    assign bus.rsp_flags       = r_rsp_flags;
    assign bus.rsp_op          = r_rsp_op;
    assign bus.rsp_timeout     = r_rsp_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_op          <= '0;
            r_b           <= '0;
            r_ready_d     <= 1'b0;
            r_data_in     <= '0;
            r_opcode      <= '0;
            r_data_valid  <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_op      <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_op          <= w_op_nxt;
            r_b           <= w_b_nxt;
            r_ready_d     <= bus.proc_data_ready;
            r_data_in     <= w_data_in_nxt;
            r_opcode      <= w_opcode_nxt;
            r_data_valid  <= w_data_valid_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_result  <= w_rsp_result_nxt;
            r_rsp_flags   <= w_rsp_flags_nxt;
            r_rsp_op      <= w_rsp_op_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    // Next-state and next-output values; outputs are loaded when entering the state that shows them.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_op_nxt          = r_op;
        w_b_nxt           = r_b;
        w_data_in_nxt     = r_data_in;
        w_opcode_nxt      = r_opcode;
        w_data_valid_nxt  = 1'b0;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_result_nxt  = r_rsp_result;
        w_rsp_flags_nxt   = r_rsp_flags;
        w_rsp_op_nxt      = r_rsp_op;
        w_rsp_timeout_nxt = r_rsp_timeout;

        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_op_nxt         = bus.cmd_op;
                    w_b_nxt          = bus.cmd_b;
                    w_data_in_nxt    = bus.cmd_a;
                    w_opcode_nxt     = bus.cmd_op;
                    w_data_valid_nxt = 1'b1;
                    w_state_nxt      = S_BEAT_A;
                end
            end
            S_BEAT_A: begin
                w_cnt_nxt   = '0;
                w_state_nxt = TWO_OPERAND_MASK[r_op] ? S_GAP : S_WAIT;
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(OPERAND_GAP - 1)) begin
                    w_data_in_nxt    = r_b;
                    w_data_valid_nxt = 1'b1;
                    w_state_nxt      = S_BEAT_B;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_BEAT_B: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving in the expiry cycle takes priority over the timeout.
                if (w_edge) begin
                    w_rsp_result_nxt  = bus.proc_data_out;
                    w_rsp_flags_nxt   = bus.proc_status;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_op_nxt      = r_op;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_rsp_result_nxt  = '0;
                    w_rsp_flags_nxt   = '0;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_op_nxt      = r_op;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tbp_cmd_issuer.sv
// Directed bench for tbp_cmd_issuer: beat shape, single/two-operand ops, timeout,
// response backpressure, reset mid-command and a held data_ready level.
module tb_tbp_cmd_issuer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tbp_cmd_issuer_if bus ();

    tbp_cmd_issuer #(
        .OPERAND_GAP      (4),
        .TIMEOUT_CYCLES   (256),
        .TWO_OPERAND_MASK (8'hBE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.proc_data_out = '0; bus.proc_data_ready = 1'b0; bus.proc_status = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode} !== 12'h000) begin
            errors++; $display("FAIL reset_proc: got %h required 000", {bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode});
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout} !== 25'h0) begin
            errors++; $display("FAIL reset_rsp: got %h required 0", {bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout});
        end
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_cmd_ready: got %b required 0", bus.cmd_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL idle_cmd_ready: got %b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_add;
        int hi;
        send_cmd(3'd1, 8'h23, 8'h45);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode} !== {1'b1, 8'h23, 3'd1}) begin
            errors++; $display("FAIL add_beat_a: got %b/%h/%0d required 1/23/1", bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL add_busy_ready: got %b required 0", bus.cmd_ready);
        end
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.proc_data_valid !== 1'b0 || bus.proc_data_in !== 8'h23) hi++;
        end
        checks++;
        if (hi !== 0) begin
            errors++; $display("FAIL add_gap: got %0d bad gap cycles required 0", hi);
        end
        @(negedge clk);
        checks++;
        if ({bus.proc_data_valid, bus.proc_data_in} !== {1'b1, 8'h45}) begin
            errors++; $display("FAIL add_beat_b: got %b/%h required 1/45", bus.proc_data_valid, bus.proc_data_in);
        end
        @(negedge clk);
        checks++;
        if (bus.proc_data_valid !== 1'b0) begin
            errors++; $display("FAIL add_after_b: got %b required 0", bus.proc_data_valid);
        end
        bus.proc_data_out = 16'h0068; bus.proc_status = 4'h3; bus.proc_data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout} !== {1'b1, 16'h0068, 4'h3, 3'd1, 1'b0}) begin
            errors++; $display("FAIL add_rsp: got v%b r%h f%h op%0d t%b required v1 r0068 f3 op1 t0",
                               bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout);
        end
        bus.rsp_ready = 1'b1; bus.proc_data_ready = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL add_rsp_done: got valid %b cmd_ready %b required 0/1", bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_single_operand;
        int hi;
        send_cmd(3'd6, 8'hAA, 8'h77);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode} !== {1'b1, 8'hAA, 3'd6}) begin
            errors++; $display("FAIL inv_beat_a: got %b/%h/%0d required 1/aa/6", bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode);
        end
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.proc_data_valid !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.proc_data_in !== 8'hAA) hi++;
        end
        checks++;
        if (hi !== 0) begin
            errors++; $display("FAIL inv_no_beat_b: got %0d bad cycles required 0", hi);
        end
        bus.proc_data_out = 16'h0055; bus.proc_status = 4'h0; bus.proc_data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_timeout} !== {1'b1, 16'h0055, 3'd6, 1'b0}) begin
            errors++; $display("FAIL inv_rsp: got v%b r%h op%0d t%b required v1 r0055 op6 t0",
                               bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_timeout);
        end
        bus.rsp_ready = 1'b1; bus.proc_data_ready = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int early;
        send_cmd(3'd0, 8'h01, 8'h00);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.proc_data_valid !== 1'b0) begin
            errors++; $display("FAIL to_wait_entry: got valid %b required 0", bus.proc_data_valid);
        end
        early = 0;
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++; $display("FAIL to_early_rsp: got %0d early cycles required 0", early);
        end
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout} !== {1'b1, 16'h0000, 4'h0, 3'd0, 1'b1}) begin
            errors++; $display("FAIL to_rsp: got v%b r%h f%h op%0d t%b required v1 r0000 f0 op0 t1",
                               bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout);
        end
    endtask

    task automatic test_backpressure;
        int bad;
        bus.rsp_ready = 1'b0;
        send_cmd(3'd2, 8'h45, 8'h23);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_timeout} !== {1'b1, 16'h0000, 4'h0, 1'b1}) bad++;
            if (bus.cmd_ready !== 1'b0 || bus.proc_data_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold: got %0d bad samples required 0", bad);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got valid %b cmd_ready %b required 0/1", bus.rsp_valid, bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode} !== {1'b1, 8'h45, 3'd2}) begin
            errors++; $display("FAIL bp_next_cmd: got %b/%h/%0d required 1/45/2", bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode);
        end
    endtask

    task automatic test_reset_in_gap;
        int hi;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode, bus.cmd_ready} !== 13'h0) begin
            errors++; $display("FAIL rst_gap_proc: got %b/%h/%0d ready %b required all 0",
                               bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode, bus.cmd_ready);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout} !== 25'h0) begin
            errors++; $display("FAIL rst_gap_rsp: got %h required 0", {bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout});
        end
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.proc_data_valid !== 1'b0) hi++;
        end
        checks++;
        if (hi !== 0) begin
            errors++; $display("FAIL rst_gap_no_beat_b: got %0d valid cycles required 0", hi);
        end
        send_cmd(3'd7, 8'h0F, 8'hF0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode} !== {1'b1, 8'h0F, 3'd7}) begin
            errors++; $display("FAIL rst_next_beat_a: got %b/%h/%0d required 1/0f/7", bus.proc_data_valid, bus.proc_data_in, bus.proc_opcode);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.proc_data_valid, bus.proc_data_in} !== {1'b1, 8'hF0}) begin
            errors++; $display("FAIL rst_next_beat_b: got %b/%h required 1/f0", bus.proc_data_valid, bus.proc_data_in);
        end
        @(negedge clk);
        bus.proc_data_out = 16'h1234; bus.proc_status = 4'hA; bus.proc_data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout} !== {1'b1, 16'h1234, 4'hA, 3'd7, 1'b0}) begin
            errors++; $display("FAIL rst_next_rsp: got v%b r%h f%h op%0d t%b required v1 r1234 fa op7 t0",
                               bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout);
        end
        bus.rsp_ready = 1'b1;
        bus.proc_data_out = 16'h1111;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_held_ready;
        int early;
        send_cmd(3'd1, 8'h01, 8'h02);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.proc_data_valid, bus.proc_data_in} !== {1'b1, 8'h02}) begin
            errors++; $display("FAIL held_beat_b: got %b/%h required 1/02", bus.proc_data_valid, bus.proc_data_in);
        end
        @(negedge clk);
        early = 0;
        for (int k = 0; k < 255; k++) begin
            if (k == 10) bus.proc_data_ready = 1'b0;
            if (bus.rsp_valid !== 1'b0) early++;
            @(negedge clk);
        end
        if (bus.rsp_valid !== 1'b0) early++;
        checks++;
        if (early !== 0) begin
            errors++; $display("FAIL held_level_captured: got %0d early cycles required 0", early);
        end
        bus.proc_data_out = 16'hBEEF; bus.proc_status = 4'h5; bus.proc_data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout} !== {1'b1, 16'hBEEF, 4'h5, 3'd1, 1'b0}) begin
            errors++; $display("FAIL held_expiry_edge: got v%b r%h f%h op%0d t%b required v1 rbeef f5 op1 t0",
                               bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_op, bus.rsp_timeout);
        end
        bus.rsp_ready = 1'b1; bus.proc_data_ready = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL held_rsp_done: got valid %b cmd_ready %b required 0/1", bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_add;
        test_single_operand;
        test_timeout;
        test_backpressure;
        test_reset_in_gap;
        test_held_ready;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
